audio_tx_axis_packer: RTL and testbench
=======================================

# audio_tx_axis_packer

Packing and buffering stage that sits between the audio processing path (DSP or volume-control output) and the audio TX AXI-Stream port. It receives 32-bit PCM samples on a valid-only interface, buffers them in a sample FIFO, and packs two samples into each 64-bit AXI-Stream beat. It applies full AXI backpressure, marks frame boundaries with `tlast`, and flushes a lone trailing sample as a half beat after an idle timeout.

## Interface
Parameters:
- `FIFO_DEPTH`, 16: sample FIFO depth in 32-bit entries; power of two, ≥4.
- `FRAME_BEATS`, 64: beats per AXI-Stream frame; `tlast` is asserted on beat `FRAME_BEATS-1`.
- `FLUSH_TIMEOUT`, 256: idle cycles before a single buffered sample is emitted as a half beat; ≥1.

Ports:
- `clk`  in  1  block clock; single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  block enable.
- `pcm_din`  in  32  PCM sample.
- `pcm_din_valid`  in  1  sample strobe, one sample per cycle; no ready signal.
- `m_axis_tdata`  out  64  packed beat: `[31:0]` is the older sample, `[63:32]` the newer.
- `m_axis_tvalid`  out  1  beat valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tkeep`  out  8  `8'hFF` for a full beat, `8'h0F` for a half beat.
- `m_axis_tlast`  out  1  end of frame.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `overflow`  out  1  sticky flag: a sample was dropped.
- `overflow_clr`  in  1  clears `overflow`.

## Operation
- **FIFO push:** a push occurs when `enable && pcm_din_valid && fifo_level < FIFO_DEPTH`. Fullness is judged on the level at the start of the cycle; a pop in the same cycle does not free a slot for that push.
- **Overflow:** if `enable && pcm_din_valid` while full, the sample is dropped and `overflow` is set. `overflow_clr` clears the flag; if a drop and a clear occur in the same cycle, set wins.
- **Output register:** holds one beat. It is free when `!m_axis_tvalid`, or when `m_axis_tvalid && m_axis_tready` in that cycle.
- **Load, full beat:** when the output register is free and `fifo_level ≥ 2`:
  - pop two entries;
  - `tdata = {second, first}`, `tkeep = 8'hFF`.
- **Load, half beat:** when the output register is free, `fifo_level == 1` and `idle_cnt == FLUSH_TIMEOUT`:
  - pop one entry;
  - `tdata = {32'h0, first}`, `tkeep = 8'h0F`, `tlast = 1`.
- **idle_cnt:**
  - increments (saturating at `FLUSH_TIMEOUT`) in each cycle where `fifo_level == 1` and no push occurs;
  - clears otherwise, and after a half-beat pop.
- **Beat counter:** `beat_cnt`, 0 … `FRAME_BEATS-1`.
  - A full beat gets `tlast = (beat_cnt == FRAME_BEATS-1)`.
  - `beat_cnt` increments on each handshake and resets to 0 on a handshake carrying `tlast`. A half beat therefore always ends the frame.
- **AXI rules:** once `tvalid` is high, `tdata`, `tkeep` and `tlast` are stable until the handshake. `tvalid` never depends combinationally on `tready`.
- **`enable` low:**
  - input is ignored and no drop is flagged;
  - FIFO, `idle_cnt` and `beat_cnt` are cleared;
  - a beat already held in the output register stays valid until it is accepted;
  - no new loads occur.
- **Reset (async, any time):** all state cleared; an in-flight beat is discarded.

## Timing
- **Reset values:**
  - `m_axis_tvalid = 0`, `m_axis_tdata = 0`, `m_axis_tkeep = 0`, `m_axis_tlast = 0`;
  - `fifo_level = 0`, `overflow = 0`;
  - internal `beat_cnt = 0`, `idle_cnt = 0`.
- **FIFO write latency:** a push in cycle N is reflected in `fifo_level` in cycle N+1.
- **Full-beat latency:** samples pushed in cycles N and N+1 produce `m_axis_tvalid` high in cycle N+3 (load at the end of N+2), with `tready` held high.
- **Back-to-back:** with continuous `tready`, one beat is sustained every 2 input cycles. At most one load per cycle.
- **Half-beat latency:** a lone sample pushed in cycle N yields `tvalid` in cycle N+FLUSH_TIMEOUT+2.
- **`overflow`:** rises the cycle after the dropped strobe.

## Test plan
- **Basic packing:** push `0x11111111`, `0x22222222` in consecutive cycles, `tready = 1` → `tdata = 0x22222222_11111111`, `tkeep = 0xFF`, `tvalid` high 3 cycles after the first push.
- **Framing:** with `FRAME_BEATS = 4`, stream 16 samples → 8 beats, `tlast` on beats 4 and 8 only, `beat_cnt` restarts after each.
- **Backpressure/overflow:** `tready = 0`, push 20 samples at `FIFO_DEPTH = 16`:
  - the first beat latches 2 samples, the FIFO fills with the next 16, and the last 2 samples are dropped;
  - `overflow = 1`, `fifo_level = 16`;
  - `tdata`/`tkeep`/`tlast` hold stable;
  - releasing `tready` drains 9 beats, and `overflow_clr` clears the flag.
- **Flush:** push one sample `0xABCD0001`, then idle, `FLUSH_TIMEOUT = 8` → beat `0x00000000_ABCD0001`, `tkeep = 0x0F`, `tlast = 1` at cycle N+10. A second sample pushed at N+5 instead produces a full beat and no flush.
- **Enable drop:** deassert `enable` while a beat is pending with `tready = 0` and 5 samples buffered → `fifo_level = 0` next cycle; the pending beat stays valid until `tready`; no further beats follow.
- **Async reset mid-frame:** assert `rst` between edges with `tvalid` high → all outputs are at their reset values immediately; after release, the first beat has `beat_cnt = 0` framing.

Source files
------------

// File: rtl/audio_tx_axis_packer.sv
// Audio TX packer: buffers 32-bit PCM samples in a FIFO and emits them as
// 64-bit AXI-Stream beats (two samples per beat), with framing and idle flush.
`timescale 1ns/1ps
module audio_tx_axis_packer #(
  parameter int FIFO_DEPTH    = 16,
  parameter int FRAME_BEATS   = 64,
  parameter int FLUSH_TIMEOUT = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [31:0]                   pcm_din,
  input  logic                          pcm_din_valid,
  output logic [63:0]                   m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [7:0]                    m_axis_tkeep,
  output logic                          m_axis_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          overflow_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int IW = $clog2(FLUSH_TIMEOUT + 1);
  localparam int BW = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(FLUSH_TIMEOUT);
  localparam logic [BW-1:0] BEAT_LAST = BW'(FRAME_BEATS - 1);

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_p1;
  logic [IW-1:0] idle_cnt;
  logic [BW-1:0] beat_cnt, beat_cnt_nxt;
  logic          push, drop, out_free, handshake, load_full, load_half;
  logic [1:0]    pop_n;
  logic [LW-1:0] level_nxt;

  always_comb begin
    push      = enable && pcm_din_valid && (fifo_level < LVL_FULL);
    drop      = enable && pcm_din_valid && (fifo_level == LVL_FULL);
    handshake = m_axis_tvalid && m_axis_tready;
    out_free  = !m_axis_tvalid || m_axis_tready;
    load_full = enable && out_free && (fifo_level >= LW'(2));
    load_half = enable && out_free && (fifo_level == LW'(1)) && (idle_cnt == IDLE_MAX);
    pop_n     = load_full ? 2'd2 : (load_half ? 2'd1 : 2'd0);
    level_nxt = fifo_level + LW'(push) - LW'(pop_n);
    rd_ptr_p1 = rd_ptr + AW'(1);
    // Frame position of a beat loaded this cycle must account for the beat
    // that may be leaving the output register in the same cycle.
    beat_cnt_nxt = beat_cnt;
    if (handshake) begin
      beat_cnt_nxt = m_axis_tlast ? '0 : beat_cnt + BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= pcm_din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      idle_cnt   <= '0;
      beat_cnt   <= '0;
    end else if (!enable) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      idle_cnt   <= '0;
      beat_cnt   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr     <= rd_ptr + AW'(pop_n);
      fifo_level <= level_nxt;
      beat_cnt   <= beat_cnt_nxt;
      if (load_half) begin
        idle_cnt <= '0;
      end else if ((fifo_level == LW'(1)) && !push) begin
        if (idle_cnt != IDLE_MAX) begin
          idle_cnt <= idle_cnt + IW'(1);
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (load_full) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= {mem[rd_ptr_p1], mem[rd_ptr]};
      m_axis_tkeep  <= 8'hFF;
      m_axis_tlast  <= (beat_cnt_nxt == BEAT_LAST);
    end else if (load_half) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= {32'h0, mem[rd_ptr]};
      m_axis_tkeep  <= 8'h0F;
      m_axis_tlast  <= 1'b1;
    end else if (handshake) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_tx_axis_packer.sv
// Scoreboard bench for audio_tx_axis_packer: a queue-based reference model
// predicts beats and occupancy; a monitor compares on every cycle/handshake.
`timescale 1ns/1ps
module tb_audio_tx_axis_packer;
  localparam int D = 16, FB = 4, FT = 8;

  logic        clk = 1'b0, rst = 1'b1, enable = 1'b0;
  logic [31:0] pcm_din = '0;
  logic        pcm_din_valid = 1'b0, m_axis_tready = 1'b0, overflow_clr = 1'b0;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, overflow;
  logic [7:0]  m_axis_tkeep;
  logic [4:0]  fifo_level;

  audio_tx_axis_packer #(.FIFO_DEPTH(D), .FRAME_BEATS(FB), .FLUSH_TIMEOUT(FT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .pcm_din(pcm_din), .pcm_din_valid(pcm_din_valid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast), .fifo_level(fifo_level),
    .overflow(overflow), .overflow_clr(overflow_clr));

  always #5 clk = ~clk;

  typedef struct { logic [63:0] data; logic [7:0] keep; logic last; } beat_t;
  beat_t       exp_q[$];
  logic [31:0] mq[$];
  bit          mv, movf;
  int          midle, mframe;
  int          n_checks = 0, n_pass = 0;
  int          beats_seen = 0, lasts_seen = 0, cyc = 0;
  bit          hold_prev = 0;
  logic [63:0] prev_data;
  logic [7:0]  prev_keep;
  logic        prev_last;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: sample queue, output slot, frame position, idle timer.
  int m_lvl; bit m_hs, m_free, m_half, m_pushed, m_drop;
  logic [31:0] m_a, m_b; beat_t m_beat;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete(); exp_q.delete();
      mv = 0; movf = 0; midle = 0; mframe = 0; hold_prev = 0;
    end else begin
      m_lvl = mq.size(); m_hs = mv && m_axis_tready; m_free = !mv || m_axis_tready;
      m_half = 0; m_pushed = 0; m_drop = 0;
      if (enable) begin
        if (m_free && m_lvl >= 2) begin
          m_a = mq.pop_front(); m_b = mq.pop_front();
          m_beat.data = {m_b, m_a}; m_beat.keep = 8'hFF; m_beat.last = (mframe == FB - 1);
          mframe = m_beat.last ? 0 : mframe + 1;
          exp_q.push_back(m_beat); mv = 1;
        end else if (m_free && m_lvl == 1 && midle == FT) begin
          m_a = mq.pop_front();
          m_beat.data = {32'h0, m_a}; m_beat.keep = 8'h0F; m_beat.last = 1'b1;
          mframe = 0; exp_q.push_back(m_beat); mv = 1; m_half = 1;
        end else if (m_hs) mv = 0;
        if (pcm_din_valid) begin
          if (m_lvl < D) begin mq.push_back(pcm_din); m_pushed = 1; end
          else m_drop = 1;
        end
        if (m_half) midle = 0;
        else if (m_lvl == 1 && !m_pushed) midle = (midle < FT) ? midle + 1 : FT;
        else midle = 0;
      end else begin
        mq.delete(); midle = 0; mframe = 0;
        if (m_hs) mv = 0;
      end
      if (m_drop) movf = 1;
      else if (overflow_clr) movf = 0;
    end
  end

  // Monitor: samples just before the next rising edge with inputs settled.
  beat_t mb;
  initial forever begin
    @(negedge clk); #2;
    if (!rst) begin
      check("tvalid", m_axis_tvalid, mv);
      check("fifo_level", fifo_level, mq.size());
      check("overflow", overflow, movf);
      if (hold_prev) begin
        check("hold_valid", m_axis_tvalid, 1);
        check("hold_data", m_axis_tdata, prev_data);
        check("hold_keep", m_axis_tkeep, prev_keep);
        check("hold_last", m_axis_tlast, prev_last);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        check("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mb = exp_q.pop_front();
          check("tdata", m_axis_tdata, mb.data);
          check("tkeep", m_axis_tkeep, mb.keep);
          check("tlast", m_axis_tlast, mb.last);
        end
        beats_seen++;
        if (m_axis_tlast) lasts_seen++;
      end
      hold_prev = m_axis_tvalid && !m_axis_tready;
      prev_data = m_axis_tdata; prev_keep = m_axis_tkeep; prev_last = m_axis_tlast;
    end else hold_prev = 0;
  end

  task automatic idle_cycle();
    @(negedge clk); pcm_din_valid = 1'b0; overflow_clr = 1'b0;
  endtask
  task automatic push(input logic [31:0] s);
    @(negedge clk); pcm_din = s; pcm_din_valid = 1'b1; overflow_clr = 1'b0;
  endtask
  task automatic wait_valid(output int lat, input int t0);
    int g = 0;
    while (!m_axis_tvalid && g < 40) begin idle_cycle(); g++; end
    lat = cyc - t0;
  endtask
  task automatic wait_idle();
    int g = 0;
    while ((mv || mq.size() != 0 || exp_q.size() != 0) && g < 300) begin idle_cycle(); g++; end
    check("drain_done", mv || exp_q.size() != 0, 0);
  endtask

  int t0, lat, b0, l0;
  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tkeep", m_axis_tkeep, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_level", fifo_level, 0);
    check("rst_overflow", overflow, 0);
    @(negedge clk); rst = 0; enable = 1; m_axis_tready = 1;

    // Basic packing and full-beat latency
    push(32'h11111111); t0 = cyc;
    push(32'h22222222);
    wait_valid(lat, t0);
    check("basic_latency", lat, 3);
    check("basic_tdata", m_axis_tdata, 64'h22222222_11111111);
    check("basic_tkeep", m_axis_tkeep, 8'hFF);
    wait_idle();

    // Framing: restart frame via enable, then 16 samples -> 8 beats, 2 tlasts
    idle_cycle(); enable = 0; idle_cycle(); enable = 1;
    b0 = beats_seen; l0 = lasts_seen;
    for (int i = 0; i < 16; i++) push(32'hF000_0000 + i);
    wait_idle();
    check("frame_beats", beats_seen - b0, 8);
    check("frame_lasts", lasts_seen - l0, 2);

    // Backpressure / overflow
    m_axis_tready = 0;
    for (int i = 0; i < 20; i++) push(32'hB000_0000 + i);
    @(negedge clk); pcm_din = 32'hB000_0014; pcm_din_valid = 1; overflow_clr = 1;
    idle_cycle();
    check("ovf_set_wins", overflow, 1);
    check("ovf_level", fifo_level, 16);
    check("ovf_held_beat", m_axis_tdata, 64'hB0000001_B0000000);
    b0 = beats_seen; m_axis_tready = 1;
    wait_idle();
    check("ovf_drain_beats", beats_seen - b0, 9);
    @(negedge clk); overflow_clr = 1;
    idle_cycle();
    check("ovf_cleared", overflow, 0);

    // Flush of a lone sample
    push(32'hABCD0001); t0 = cyc;
    wait_valid(lat, t0);
    check("flush_latency", lat, FT + 2);
    check("flush_tdata", m_axis_tdata, 64'h00000000_ABCD0001);
    check("flush_tkeep", m_axis_tkeep, 8'h0F);
    check("flush_tlast", m_axis_tlast, 1);
    wait_idle();
    push(32'hABCD0002); t0 = cyc;
    repeat (4) idle_cycle();
    push(32'hABCD0003);
    wait_valid(lat, t0);
    check("noflush_tkeep", m_axis_tkeep, 8'hFF);
    check("noflush_tdata", m_axis_tdata, 64'hABCD0003_ABCD0002);
    wait_idle();

    // Enable drop with a pending beat
    m_axis_tready = 0;
    for (int i = 0; i < 7; i++) push(32'hE000_0000 + i);
    idle_cycle();
    check("en_level_before", fifo_level, 5);
    enable = 0;
    idle_cycle();
    check("en_level_cleared", fifo_level, 0);
    check("en_pending_valid", m_axis_tvalid, 1);
    b0 = beats_seen;
    repeat (3) push(32'h5555_0000);
    m_axis_tready = 1;
    repeat (12) idle_cycle();
    check("en_single_beat", beats_seen - b0, 1);
    check("en_no_more_valid", m_axis_tvalid, 0);
    enable = 1;

    // Async reset with a beat held
    m_axis_tready = 0;
    for (int i = 0; i < 4; i++) push(32'hC000_0000 + i);
    idle_cycle();
    check("pre_reset_valid", m_axis_tvalid, 1);
    #3 rst = 1; pcm_din_valid = 0;
    #1;
    check("async_tvalid", m_axis_tvalid, 0);
    check("async_tdata", m_axis_tdata, 0);
    check("async_tkeep", m_axis_tkeep, 0);
    check("async_tlast", m_axis_tlast, 0);
    check("async_level", fifo_level, 0);
    @(negedge clk); rst = 0; m_axis_tready = 1;
    b0 = beats_seen; l0 = lasts_seen;
    for (int i = 0; i < 8; i++) push(32'hD000_0000 + i);
    wait_idle();
    check("post_reset_beats", beats_seen - b0, 4);
    check("post_reset_lasts", lasts_seen - l0, 1);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (enable && $urandom_range(0, 99) < 2) enable = 0;
      else if (!enable && !mv && $urandom_range(0, 99) < 30) enable = 1;
      pcm_din_valid = ($urandom_range(0, 99) < 60);
      pcm_din       = $urandom;
      m_axis_tready = ($urandom_range(0, 99) < 70);
      overflow_clr  = ($urandom_range(0, 99) < 3);
    end
    @(negedge clk); enable = 1; pcm_din_valid = 0; overflow_clr = 0; m_axis_tready = 1;
    wait_idle();
    repeat (3) idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end
endmodule
